up_down_counter_mod: RTL and testbench

Parametrised synchronous up/down counter with programmable terminal value, parallel load, count enable, wrap or saturate mode and a selectable active clock edge. It is the general-purpose successor to the fixed-direction load counter, and it is used wherever the design needs modulo-N counting, timeouts or event tallies on either clock edge. Status flags are registered, so downstream logic sees a clean single-cycle wrap pulse and a sticky overflow indication.

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_next_calc.sv | 38 +++
 rtl/up_down_counter_mod.sv | 81 ++++++++
 tb/tb_up_down_counter_mod.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the up/down counter family.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count and limit-event computation for one counting step.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_down_i,
  input  logic [WIDTH-1:0] term_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             event_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    next_o  = count_i;
    event_o = 1'b0;
    if (up_down_i == DIR_UP) begin
      // ">=" so a count left above a lowered terminal value still hits the limit
      if (count_i >= term_i) begin
        event_o = 1'b1;
        next_o  = (mode_i == MODE_SAT) ? term_i : '0;
      end else begin
        next_o = count_i + ONE;
      end
    end else begin
      if (count_i == '0) begin
        event_o = 1'b1;
        next_o  = (mode_i == MODE_SAT) ? '0 : term_i;
      end else begin
        next_o = count_i - ONE;
      end
    end
  end

endmodule

// File: rtl/up_down_counter_mod.sv
// Up/down counter with load, terminal value, wrap/saturate mode, registered
// wrap pulse and sticky flag, clocked on the edge chosen by NEG_EDGE.
module up_down_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NEG_EDGE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] terminal_value,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter_output,
  output logic             wrap_pulse,
  output logic             wrap_sticky
);

  localparam mode_e MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] calc_next;
  logic             calc_event;

  counter_next_calc #(
    .WIDTH(WIDTH)
  ) u_next_calc (
    .count_i  (count_q),
    .up_down_i(up_down),
    .term_i   (terminal_value),
    .mode_i   (MODE),
    .next_o   (calc_next),
    .event_o  (calc_event)
  );

  // Priority: reset > load > enable > hold. A limit event beats clear_flags.
  always_comb begin
    count_d  = count_q;
    pulse_d  = 1'b0;
    sticky_d = sticky_q & ~clear_flags;
    if (reset) begin
      count_d  = '0;
      sticky_d = 1'b0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable) begin
      count_d = calc_next;
      pulse_d = calc_event;
      if (calc_event) begin
        sticky_d = 1'b1;
      end
    end
  end

  generate
    if (NEG_EDGE != 0) begin : g_neg_edge
      always_ff @(negedge clock0) begin
        count_q  <= count_d;
        pulse_q  <= pulse_d;
        sticky_q <= sticky_d;
      end
    end else begin : g_pos_edge
      always_ff @(posedge clock0) begin
        count_q  <= count_d;
        pulse_q  <= pulse_d;
        sticky_q <= sticky_d;
      end
    end
  endgenerate

  assign counter_output = count_q;
  assign wrap_pulse     = pulse_q;
  assign wrap_sticky    = sticky_q;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Bench for up_down_counter_mod: vector table through a scoreboard, plus an
// edge-select sequence comparing falling-edge and rising-edge instances.
module tb_up_down_counter_mod;

  localparam int CW = 8;
  localparam int W  = CW + 3;

  logic          clk = 1'b0;
  logic          rst, ld, en, up, clr;
  logic [CW-1:0] lv, tv;

  logic [CW-1:0] w_cnt, s_cnt, p_cnt;
  logic          w_p, w_s, s_p, s_s, p_p, p_s;

  typedef struct {
    string         name;
    logic          sel;
    logic          r, l, e, u, c;
    logic [CW-1:0] lv, tv;
    logic [CW-1:0] cnt;
    logic          p, s;
  } vec_t;

  vec_t          vecs[$];
  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  up_down_counter_mod #(.WIDTH(CW), .NEG_EDGE(1), .SATURATE(0)) dut_w (
    .clock0(clk), .reset(rst), .enable(en), .up_down(up), .load(ld),
    .load_value(lv), .terminal_value(tv), .clear_flags(clr),
    .counter_output(w_cnt), .wrap_pulse(w_p), .wrap_sticky(w_s)
  );

  up_down_counter_mod #(.WIDTH(CW), .NEG_EDGE(1), .SATURATE(1)) dut_s (
    .clock0(clk), .reset(rst), .enable(en), .up_down(up), .load(ld),
    .load_value(lv), .terminal_value(tv), .clear_flags(clr),
    .counter_output(s_cnt), .wrap_pulse(s_p), .wrap_sticky(s_s)
  );

  up_down_counter_mod #(.WIDTH(CW), .NEG_EDGE(0), .SATURATE(0)) dut_p (
    .clock0(clk), .reset(rst), .enable(en), .up_down(up), .load(ld),
    .load_value(lv), .terminal_value(tv), .clear_flags(clr),
    .counter_output(p_cnt), .wrap_pulse(p_p), .wrap_sticky(p_s)
  );

  function automatic vec_t mk(string n, bit sel, bit r, bit l, bit e, bit u,
                              bit c, int lval, int tval, int cnt, bit p, bit s);
    vec_t v;
    v.name = n; v.sel = sel;
    v.r = r; v.l = l; v.e = e; v.u = u; v.c = c;
    v.lv = lval[CW-1:0]; v.tv = tval[CW-1:0]; v.cnt = cnt[CW-1:0];
    v.p = p; v.s = s;
    return v;
  endfunction

  task automatic chk(string n, logic [CW-1:0] act, logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.r; ld = v.l; en = v.e; up = v.u; clr = v.c;
    lv = v.lv; tv = v.tv;
  endtask

  task automatic score(string n);
    logic [W-1:0]  e;
    logic [CW-1:0] a_cnt;
    logic          a_p, a_s;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty got 0 entries required 1", n);
      return;
    end
    e = exp_q.pop_front();
    a_cnt = e[W-1] ? s_cnt : w_cnt;
    a_p   = e[W-1] ? s_p   : w_p;
    a_s   = e[W-1] ? s_s   : w_s;
    chk({n, ".count"},  a_cnt, e[CW+1:2]);
    chk({n, ".pulse"},  {7'd0, a_p}, {7'd0, e[1]});
    chk({n, ".sticky"}, {7'd0, a_s}, {7'd0, e[0]});
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0;
    lv = '0; tv = '0;

    // Wrap up, T=9: 1..9, 0 (event), 1, 2
    vecs.push_back(mk("rst",    0, 1,0,0,1,0,   0,  9,   0, 0,0));
    for (int i = 1; i <= 9; i++)
      vecs.push_back(mk("wup",  0, 0,0,1,1,0,   0,  9,   i, 0,0));
    vecs.push_back(mk("wup0",   0, 0,0,1,1,0,   0,  9,   0, 1,1));
    vecs.push_back(mk("wup1",   0, 0,0,1,1,0,   0,  9,   1, 0,1));
    vecs.push_back(mk("wup2",   0, 0,0,1,1,0,   0,  9,   2, 0,1));
    // Wrap down from 2: 1, 0, 9 (event), 8
    vecs.push_back(mk("ld2",    0, 0,1,0,0,0,   2,  9,   2, 0,1));
    vecs.push_back(mk("wdn1",   0, 0,0,1,0,0,   0,  9,   1, 0,1));
    vecs.push_back(mk("wdn0",   0, 0,0,1,0,0,   0,  9,   0, 0,1));
    vecs.push_back(mk("wdn9",   0, 0,0,1,0,0,   0,  9,   9, 1,1));
    vecs.push_back(mk("wdn8",   0, 0,0,1,0,0,   0,  9,   8, 0,1));
    vecs.push_back(mk("clr",    0, 0,0,0,0,1,   0,  9,   8, 0,0));
    // Priority cases
    vecs.push_back(mk("rle",    0, 1,1,1,1,1,8'h55, 9,   0, 0,0));
    vecs.push_back(mk("ld9",    0, 0,1,0,1,0,   9,  9,   9, 0,0));
    vecs.push_back(mk("ldpri",  0, 0,1,1,1,0,8'hAB, 9,8'hAB,0,0));
    vecs.push_back(mk("ld9b",   0, 0,1,0,1,0,   9,  9,   9, 0,0));
    vecs.push_back(mk("clrwrap",0, 0,0,1,1,1,   0,  9,   0, 1,1));
    vecs.push_back(mk("clronly",0, 0,0,0,1,1,   0,  9,   0, 0,0));
    // Full range T=255: 255, 0 (event), 1
    vecs.push_back(mk("ld254",  0, 0,1,0,1,0, 254,255, 254, 0,0));
    vecs.push_back(mk("fr255",  0, 0,0,1,1,0,   0,255, 255, 0,0));
    vecs.push_back(mk("fr0",    0, 0,0,1,1,0,   0,255,   0, 1,1));
    vecs.push_back(mk("fr1",    0, 0,0,1,1,0,   0,255,   1, 0,1));
    // T=0: every enabled cycle is an event in either direction
    vecs.push_back(mk("t0up_a", 0, 0,0,1,1,0,   0,  0,   0, 1,1));
    vecs.push_back(mk("t0up_b", 0, 0,0,1,1,0,   0,  0,   0, 1,1));
    vecs.push_back(mk("t0dn",   0, 0,0,1,0,0,   0,  0,   0, 1,1));
    // T lowered below the count, hold after event, oversize load
    vecs.push_back(mk("ld7",    0, 0,1,0,1,0,   7,  9,   7, 0,1));
    vecs.push_back(mk("tdrop",  0, 0,0,1,1,0,   0,  5,   0, 1,1));
    vecs.push_back(mk("holdp",  0, 0,0,0,1,0,   0,  5,   0, 0,1));
    vecs.push_back(mk("ldbig",  0, 0,1,0,1,0, 200,  9, 200, 0,1));
    vecs.push_back(mk("dnbig",  0, 0,0,1,0,0,   0,  9, 199, 0,1));
    vecs.push_back(mk("hold",   0, 0,0,0,1,0,   0,  9, 199, 0,1));
    // Saturate instance, T=200: 199, 200, then 200 with events
    vecs.push_back(mk("srst",   1, 1,0,0,1,0,   0,200,   0, 0,0));
    vecs.push_back(mk("sld198", 1, 0,1,0,1,0, 198,200, 198, 0,0));
    vecs.push_back(mk("s199",   1, 0,0,1,1,0,   0,200, 199, 0,0));
    vecs.push_back(mk("s200",   1, 0,0,1,1,0,   0,200, 200, 0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("shit", 1, 0,0,1,1,0,   0,200, 200, 1,1));
    vecs.push_back(mk("sld0",   1, 0,1,0,1,0,   0,200,   0, 0,1));
    vecs.push_back(mk("sdn0",   1, 0,0,1,0,0,   0,200,   0, 1,1));
    vecs.push_back(mk("sup1",   1, 0,0,1,1,0,   0,200,   1, 0,1));
    vecs.push_back(mk("sldbig", 1, 0,1,0,1,0, 250,200, 250, 0,1));
    vecs.push_back(mk("sover",  1, 0,0,1,1,0,   0,200, 200, 1,1));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      exp_q.push_back({vecs[i].sel, vecs[i].cnt, vecs[i].p, vecs[i].s});
      @(negedge clk);
      #2;
      score(vecs[i].name);
    end

    // Edge select: falling-edge instance moves only between mid-high and
    // mid-low samples, rising-edge instance only between mid-low and mid-high.
    @(posedge clk);
    #1;
    rst = 1'b1; ld = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; tv = 8'd255;
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2;
      chk("edge.neg.high", w_cnt, CW'(k + 1));
      chk("edge.pos.high", p_cnt, CW'(k + 1));
      @(negedge clk);
      #2;
      chk("edge.neg.low",  w_cnt, CW'(k + 2));
      chk("edge.pos.low",  p_cnt, CW'(k + 1));
    end
    chk("edge.pos.pulse", {7'd0, p_p}, 8'd0);
    chk("edge.pos.sticky", {7'd0, p_s}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
